// File: rtl/hc_mmio_rd_responder_pkg.sv
// Shared HardCloud definitions: CCI-P MMIO channel types, register map,
// run-state encoding and the MMIO read register-select helper.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package hc_mmio_rd_responder_pkg;

   // ---------------- CCI-P subset used by the MMIO paths ----------------
   typedef logic [8:0]  t_ccip_tid;
   typedef logic [15:0] t_ccip_mmioAddr;
   typedef logic [63:0] t_ccip_mmioData;

   typedef struct packed {
      t_ccip_mmioAddr address;   // 4B word index
      logic [1:0]     length;    // 0: 4B, 1: 8B
      logic           rsvd;
      t_ccip_tid      tid;
   } t_ccip_c0_ReqMmioHdr;

   localparam int CCIP_C0_HDR_W = $bits(t_ccip_c0_ReqMmioHdr);
   typedef logic [CCIP_C0_HDR_W-1:0] t_ccip_c0_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      logic [511:0]       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      t_ccip_tid tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      t_ccip_mmioData      data;
   } t_if_ccip_c2_Tx;

   // ---------------- HardCloud registers ----------------
   localparam int HC_BUFFER_SIZE = 2;

   typedef struct packed {
      logic [63:0] address;
      logic [31:0] size;
   } t_hc_buffer;

   localparam logic [31:0] HC_CONTROL_ASSERT_RST   = 32'h0000_0000;
   localparam logic [31:0] HC_CONTROL_DEASSERT_RST = 32'h0000_0001;
   localparam logic [31:0] HC_CONTROL_START        = 32'h0000_0003;
   localparam logic [31:0] HC_CONTROL_STOP         = 32'h0000_0007;

   // Byte offsets
   localparam logic [15:0] HC_DSM_BASE    = 16'h110;
   localparam logic [15:0] HC_CONTROL     = 16'h118;
   localparam logic [15:0] HC_BUFFER_BASE = 16'h120;
   localparam logic [15:0] HC_STATUS      = 16'h180;
   localparam logic [15:0] HC_RUN_CYCLES  = 16'h188;
   localparam logic [15:0] HC_RD_COUNT    = 16'h190;

   typedef enum logic [1:0] {
      S_RUN_IDLE = 2'd0,
      S_RUN_BUSY = 2'd1,
      S_RUN_DONE = 2'd2
   } t_hc_run_state;

   typedef enum logic [3:0] {
      SEL_ZERO,
      SEL_DFH,
      SEL_ID_L,
      SEL_ID_H,
      SEL_DSM_BASE,
      SEL_CONTROL,
      SEL_BUF_ADDR,
      SEL_BUF_SIZE,
      SEL_STATUS,
      SEL_RUN_CYCLES,
      SEL_RD_COUNT
   } t_hc_reg_sel;

   typedef struct packed {
      t_hc_reg_sel sel;
      logic [7:0]  buf_idx;   // meaningful only for SEL_BUF_*
   } t_hc_rd_sel;

   // Map a 4B word address onto the 64b register it belongs to. Both halves
   // of a qword select the same register; the half is resolved downstream.
   function automatic t_hc_rd_sel hc_mmio_rd_sel_addr(input t_ccip_mmioAddr word_addr,
                                                      input int             num_buffers);
      logic [17:0] qword;
      logic [17:0] buf_off;
      t_hc_rd_sel  r;
      qword     = {word_addr[15:1], 3'b000};
      buf_off   = qword - 18'(HC_BUFFER_BASE);
      r.sel     = SEL_ZERO;
      r.buf_idx = '0;
      case (qword)
         18'h000:             r.sel = SEL_DFH;
         18'h008:             r.sel = SEL_ID_L;
         18'h010:             r.sel = SEL_ID_H;
         18'(HC_DSM_BASE):    r.sel = SEL_DSM_BASE;
         18'(HC_CONTROL):     r.sel = SEL_CONTROL;
         18'(HC_STATUS):      r.sel = SEL_STATUS;
         18'(HC_RUN_CYCLES):  r.sel = SEL_RUN_CYCLES;
         18'(HC_RD_COUNT):    r.sel = SEL_RD_COUNT;
         default: begin
            // Descriptor i occupies 16 bytes: address qword then size qword.
            if (qword >= 18'(HC_BUFFER_BASE) &&
                qword < 18'(HC_BUFFER_BASE) + 18'(num_buffers * 16)) begin
               r.sel     = buf_off[3] ? SEL_BUF_SIZE : SEL_BUF_ADDR;
               r.buf_idx = buf_off[11:4];
            end
         end
      endcase
      return r;
   endfunction

   function automatic t_hc_rd_sel hc_mmio_rd_sel(input t_if_ccip_c0_Rx rx);
      t_ccip_c0_ReqMmioHdr h;
      h = t_ccip_c0_ReqMmioHdr'(rx.hdr);
      return hc_mmio_rd_sel_addr(h.address, HC_BUFFER_SIZE);
   endfunction

endpackage

// File: rtl/hc_mmio_rd_decode.sv
// MMIO read address decode: 4B word address -> register select and half.
// Latency: combinational. Backpressure: none.
// Ports: word_addr (in, 16) | rd_sel (out, t_hc_rd_sel) | hi_half (out, odd 4B word)
module hc_mmio_rd_decode
   import hc_mmio_rd_responder_pkg::*;
#(
   parameter int NUM_BUFFERS = HC_BUFFER_SIZE
)(
   input  logic [15:0] word_addr,
   output t_hc_rd_sel  rd_sel,
   output logic        hi_half
);

   assign rd_sel  = hc_mmio_rd_sel_addr(word_addr, NUM_BUFFERS);
   assign hi_half = word_addr[0];

endmodule

// File: rtl/hc_mmio_rd_responder.sv
// CCI-P MMIO read responder: DFH/AFU_ID, register readback, run FSM status.
// Latency: 2 clk request->response, 1 read/clk sustained, in order.
// Backpressure: none; c2 cannot stall. Optional RD_COUNT via HC_MMIO_RD_STATS_EN.
// Ports: clk, reset_n (sync, active low) | rx_c0 (MMIO req) | tx_c2 (MMIO rsp)
//        dsm_base, hc_control, hc_buffer (register values) | done (pulse) | run_state
module hc_mmio_rd_responder
   import hc_mmio_rd_responder_pkg::*;
#(
   parameter logic [63:0] AFU_DFH     = 64'h1000_0000_0000_1001,
   parameter logic [63:0] AFU_ID_L    = 64'h0,
   parameter logic [63:0] AFU_ID_H    = 64'h0,
   parameter int          NUM_BUFFERS = HC_BUFFER_SIZE
)(
   input  logic           clk,
   input  logic           reset_n,
   input  t_if_ccip_c0_Rx rx_c0,
   output t_if_ccip_c2_Tx tx_c2,
   input  logic [63:0]    dsm_base,
   input  logic [31:0]    hc_control,
   input  t_hc_buffer     hc_buffer [NUM_BUFFERS],
   input  logic           done,
   output t_hc_run_state  run_state
);

   t_ccip_c0_ReqMmioHdr req_hdr;
   t_hc_rd_sel          rd_sel;
   logic                rd_hi;

   assign req_hdr = t_ccip_c0_ReqMmioHdr'(rx_c0.hdr);

   logic unused_rx;
   assign unused_rx = ^{rx_c0.data, rx_c0.rspValid, rx_c0.mmioWrValid, req_hdr.rsvd};

   hc_mmio_rd_decode #(
      .NUM_BUFFERS (NUM_BUFFERS)
   ) u_decode (
      .word_addr (req_hdr.address),
      .rd_sel    (rd_sel),
      .hi_half   (rd_hi)
   );

   logic        done_latched;
   logic [63:0] run_cycles;
   logic [63:0] rd_count_view;   // RD_COUNT as seen by the read being accepted

`ifdef HC_MMIO_RD_STATS_EN
   logic [63:0] rd_count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_count <= '0;
      end else if (rx_c0.mmioRdValid) begin
         rd_count <= rd_count + 64'd1;
      end
   end

   // The count includes the read that is returning it.
   assign rd_count_view = rd_count + 64'd1;
`else
   assign rd_count_view = '0;
`endif

   // Register value at the accept edge. Capturing it in stage 1 (rather than
   // muxing in stage 2) makes a read that races an FSM transition return the
   // pre-edge value.
   logic [63:0] reg_val;

   always_comb begin
      reg_val = '0;
      case (rd_sel.sel)
         SEL_DFH:        reg_val = AFU_DFH;
         SEL_ID_L:       reg_val = AFU_ID_L;
         SEL_ID_H:       reg_val = AFU_ID_H;
         SEL_DSM_BASE:   reg_val = dsm_base;
         SEL_CONTROL:    reg_val = {32'h0, hc_control};
         SEL_BUF_ADDR: begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
               if (rd_sel.buf_idx == 8'(i)) reg_val = hc_buffer[i].address;
            end
         end
         SEL_BUF_SIZE: begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
               if (rd_sel.buf_idx == 8'(i)) reg_val = {32'h0, hc_buffer[i].size};
            end
         end
         SEL_STATUS:     reg_val = {61'h0, done_latched, run_state};
         SEL_RUN_CYCLES: reg_val = run_cycles;
         SEL_RD_COUNT:   reg_val = rd_count_view;
         default:        reg_val = '0;
      endcase
   end

   // ---------------- stage 1 ----------------
   logic        s1_vld;
   t_ccip_tid   s1_tid;
   logic        s1_is_4b;
   logic        s1_hi;
   logic [63:0] s1_val;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_vld   <= 1'b0;
         s1_tid   <= '0;
         s1_is_4b <= 1'b0;
         s1_hi    <= 1'b0;
         s1_val   <= '0;
      end else begin
         s1_vld <= rx_c0.mmioRdValid;
         if (rx_c0.mmioRdValid) begin
            s1_tid   <= req_hdr.tid;
            s1_is_4b <= (req_hdr.length == 2'b00);
            s1_hi    <= rd_hi;
            s1_val   <= reg_val;
         end
      end
   end

   // ---------------- stage 2 ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_c2 <= '0;
      end else begin
         tx_c2 <= '0;
         if (s1_vld) begin
            tx_c2.mmioRdValid <= 1'b1;
            tx_c2.hdr.tid     <= s1_tid;
            // 4B reads always land in data[31:0], upper half zero.
            tx_c2.data        <= s1_is_4b ? {32'h0, (s1_hi ? s1_val[63:32] : s1_val[31:0])}
                                          : s1_val;
         end
      end
   end

   // ---------------- run FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         run_state    <= S_RUN_IDLE;
         run_cycles   <= '0;
         done_latched <= 1'b0;
      end else begin
         case (run_state)
            S_RUN_IDLE: begin
               if (hc_control == HC_CONTROL_START) begin
                  run_state    <= S_RUN_BUSY;
                  run_cycles   <= '0;
                  done_latched <= 1'b0;
               end
            end
            S_RUN_BUSY: begin
               if (run_cycles != '1) run_cycles <= run_cycles + 64'd1;
               // Host reset wins over a kernel done in the same cycle.
               if (hc_control == HC_CONTROL_ASSERT_RST) begin
                  run_state <= S_RUN_IDLE;
               end else if (done) begin
                  run_state    <= S_RUN_DONE;
                  done_latched <= 1'b1;
               end else if (hc_control == HC_CONTROL_STOP) begin
                  run_state <= S_RUN_DONE;
               end
            end
            S_RUN_DONE: begin
               if (hc_control == HC_CONTROL_ASSERT_RST) run_state <= S_RUN_IDLE;
            end
            default: run_state <= S_RUN_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// Self-checking bench for hc_mmio_rd_responder: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_hc_mmio_rd_responder;
   import hc_mmio_rd_responder_pkg::*;

   localparam logic [63:0] TB_DFH  = 64'h1000_0000_0000_1001;
   localparam logic [63:0] TB_ID_L = 64'hDEAD_BEEF_0123_4567;
   localparam logic [63:0] TB_ID_H = 64'h0123_4567_89AB_CDEF;
   localparam int          NB      = 2;

   logic           clk = 1'b0;
   logic           reset_n;
   t_if_ccip_c0_Rx rx_c0;
   t_if_ccip_c2_Tx tx_c2;
   logic [63:0]    dsm_base;
   logic [31:0]    hc_control;
   t_hc_buffer     hc_buffer [NB];
   logic           done;
   t_hc_run_state  run_state;

   always #5 clk = ~clk;

   hc_mmio_rd_responder #(
      .AFU_DFH     (TB_DFH),
      .AFU_ID_L    (TB_ID_L),
      .AFU_ID_H    (TB_ID_H),
      .NUM_BUFFERS (NB)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_c0      (rx_c0),
      .tx_c2      (tx_c2),
      .dsm_base   (dsm_base),
      .hc_control (hc_control),
      .hc_buffer  (hc_buffer),
      .done       (done),
      .run_state  (run_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int              m_state;      // 0 idle, 1 busy, 2 done
   longint unsigned m_cycles;
   bit              m_latched;
   longint unsigned m_rdcnt;
   int              ncyc = 0;

   typedef struct { int due; logic [8:0] tid; logic [63:0] data; } rsp_t;
   typedef struct { int cyc; logic [8:0] tid; logic [63:0] data; } got_t;
   rsp_t exp_q[$];
   got_t got_q[$];

   function automatic logic [63:0] ref_reg(input int off);
      if (off == 'h000) return TB_DFH;
      if (off == 'h008) return TB_ID_L;
      if (off == 'h010) return TB_ID_H;
      if (off == 'h110) return dsm_base;
      if (off == 'h118) return {32'h0, hc_control};
      if (off >= 'h120 && off < 'h120 + 16 * NB) begin
         int i;
         i = (off - 'h120) / 16;
         if ((off - 'h120) % 16 == 0) return hc_buffer[i].address;
         return {32'h0, hc_buffer[i].size};
      end
      if (off == 'h180) return 64'(m_latched) * 4 + 64'(m_state);
      if (off == 'h188) return m_cycles;
`ifdef HC_MMIO_RD_STATS_EN
      if (off == 'h190) return m_rdcnt + 1;
`endif
      return 64'h0;
   endfunction

   function automatic logic [63:0] ref_rsp(input logic [15:0] word, input logic [1:0] len);
      logic [63:0] r;
      int          byte_off;
      byte_off = int'(word) * 4;
      r = ref_reg(byte_off & ~7);
      if (len != 2'd0) return r;
      if ((byte_off & 4) != 0) return {32'h0, r[63:32]};
      return {32'h0, r[31:0]};
   endfunction

   // Applies the effect of the coming clock edge to the model.
   task automatic model_edge();
      t_ccip_c0_ReqMmioHdr h;
      if (!reset_n) begin
         exp_q.delete();
         m_state = 0; m_cycles = 0; m_latched = 0; m_rdcnt = 0;
         return;
      end
      if (rx_c0.mmioRdValid) begin
         h = t_ccip_c0_ReqMmioHdr'(rx_c0.hdr);
         exp_q.push_back('{due: ncyc + 2, tid: h.tid, data: ref_rsp(h.address, h.length)});
         m_rdcnt++;
      end
      case (m_state)
         0: if (hc_control == HC_CONTROL_START) begin
               m_state = 1; m_cycles = 0; m_latched = 0;
            end
         1: begin
               if (m_cycles != 64'hFFFF_FFFF_FFFF_FFFF) m_cycles++;
               if (hc_control == HC_CONTROL_ASSERT_RST) m_state = 0;
               else if (done) begin m_state = 2; m_latched = 1; end
               else if (hc_control == HC_CONTROL_STOP) m_state = 2;
            end
         default: if (hc_control == HC_CONTROL_ASSERT_RST) m_state = 0;
      endcase
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      ncyc++;
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == ncyc) begin
         rsp_t e;
         e = exp_q.pop_front();
         chk("rsp_vld", 64'(tx_c2.mmioRdValid), 64'd1);
         chk("rsp_tid", 64'(tx_c2.hdr.tid), 64'(e.tid));
         chk("rsp_data", tx_c2.data, e.data);
      end else begin
         chk("idle_vld", 64'(tx_c2.mmioRdValid), 64'd0);
      end
      chk("run_state", 64'(run_state), 64'(m_state));
      if (tx_c2.mmioRdValid) got_q.push_back('{cyc: ncyc, tid: tx_c2.hdr.tid, data: tx_c2.data});
   endtask

   task automatic rd(input logic [15:0] word, input logic [1:0] len, input logic [8:0] tid);
      t_ccip_c0_ReqMmioHdr h;
      h = '0;
      h.address = word;
      h.length  = len;
      h.tid     = tid;
      rx_c0 = '0;
      rx_c0.hdr = h;
      rx_c0.mmioRdValid = 1'b1;
      tick();
      rx_c0 = '0;
   endtask

   typedef struct { logic [15:0] word; logic [1:0] len; logic [8:0] tid; logic [63:0] exp; } vec_t;
   vec_t vt[17];

   initial begin
      vt[0]  = '{16'h002, 2'd1, 9'h01A, 64'hDEAD_BEEF_0123_4567};
      vt[1]  = '{16'h000, 2'd1, 9'h001, 64'h1000_0000_0000_1001};
      vt[2]  = '{16'h004, 2'd1, 9'h002, 64'h0123_4567_89AB_CDEF};
      vt[3]  = '{16'h005, 2'd0, 9'h003, 64'h0000_0000_0123_4567};
      vt[4]  = '{16'h049, 2'd0, 9'h004, 64'h0000_0000_AABB_CCDD};
      vt[5]  = '{16'h048, 2'd0, 9'h005, 64'h0000_0000_1122_3344};
      vt[6]  = '{16'h04A, 2'd1, 9'h006, 64'h0000_0000_0000_1000};
      vt[7]  = '{16'h04C, 2'd1, 9'h007, 64'h5566_7788_99AA_BBCC};
      vt[8]  = '{16'h04F, 2'd0, 9'h008, 64'h0};
      vt[9]  = '{16'h04E, 2'd0, 9'h009, 64'h0000_0000_0002_0000};
      vt[10] = '{16'h050, 2'd1, 9'h00A, 64'h0};
      vt[11] = '{16'h045, 2'd1, 9'h00B, 64'h0000_0F00_DCBA_9870};
      vt[12] = '{16'h047, 2'd0, 9'h00C, 64'h0};
      vt[13] = '{16'h046, 2'd0, 9'h1FF, 64'h0000_0000_0000_0001};
      vt[14] = '{16'h006, 2'd1, 9'h00E, 64'h0};
      vt[15] = '{16'h060, 2'd1, 9'h00F, 64'h0};
      vt[16] = '{16'h062, 2'd1, 9'h010, 64'h0};

      reset_n    = 1'b0;
      rx_c0      = '0;
      done       = 1'b0;
      dsm_base   = 64'h0000_0F00_DCBA_9870;
      hc_control = HC_CONTROL_DEASSERT_RST;
      hc_buffer[0] = '{address: 64'hAABB_CCDD_1122_3344, size: 32'h0000_1000};
      hc_buffer[1] = '{address: 64'h5566_7788_99AA_BBCC, size: 32'h0002_0000};

      // Reset state
      repeat (3) tick();
      chk("rst_tx_zero", 64'(|tx_c2), 64'd0);
      reset_n = 1'b1;
      tick();

      // Vector table
      foreach (vt[k]) begin
         got_q.delete();
         rd(vt[k].word, vt[k].len, vt[k].tid);
         tick();
         chk("tbl_count", 64'(got_q.size()), 64'd1);
         if (got_q.size() > 0) begin
            chk("tbl_tid", 64'(got_q[0].tid), 64'(vt[k].tid));
            chk("tbl_data", got_q[0].data, vt[k].exp);
         end
      end

      // Back-to-back reads, in order, one per cycle
      got_q.delete();
      rd(16'h044, 2'd1, 9'd1);
      rd(16'h046, 2'd1, 9'd2);
      rd(16'h0FE, 2'd1, 9'd3);
      repeat (3) tick();
      chk("b2b_count", 64'(got_q.size()), 64'd3);
      if (got_q.size() == 3) begin
         chk("b2b_tid0", 64'(got_q[0].tid), 64'd1);
         chk("b2b_tid1", 64'(got_q[1].tid), 64'd2);
         chk("b2b_tid2", 64'(got_q[2].tid), 64'd3);
         chk("b2b_dat0", got_q[0].data, 64'h0000_0F00_DCBA_9870);
         chk("b2b_dat1", got_q[1].data, 64'h0000_0000_0000_0001);
         chk("b2b_dat2", got_q[2].data, 64'h0);
         chk("b2b_gap", 64'(got_q[2].cyc - got_q[0].cyc), 64'd2);
      end

      // START for 100 busy cycles, then done
      hc_control = HC_CONTROL_START;
      tick();
      repeat (99) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      hc_control = HC_CONTROL_DEASSERT_RST;
      chk("run_done_state", 64'(run_state), 64'd2);
      got_q.delete();
      rd(16'h062, 2'd1, 9'h020);
      rd(16'h060, 2'd1, 9'h021);
      repeat (2) tick();
      chk("run_rsp_count", 64'(got_q.size()), 64'd2);
      if (got_q.size() == 2) begin
         chk("run_cycles", got_q[0].data, 64'd100);
         chk("run_status", got_q[1].data, 64'h6);
      end

      // ASSERT_RST in the same cycle as done
      hc_control = HC_CONTROL_ASSERT_RST;
      tick();
      hc_control = HC_CONTROL_START;
      tick();
      hc_control = HC_CONTROL_DEASSERT_RST;
      repeat (3) tick();
      hc_control = HC_CONTROL_ASSERT_RST;
      done = 1'b1;
      tick();
      done = 1'b0;
      hc_control = HC_CONTROL_DEASSERT_RST;
      chk("rst_done_state", 64'(run_state), 64'd0);
      repeat (3) tick();
      got_q.delete();
      rd(16'h060, 2'd1, 9'h030);
      rd(16'h062, 2'd1, 9'h031);
      repeat (2) tick();
      chk("rst_done_count", 64'(got_q.size()), 64'd2);
      if (got_q.size() == 2) begin
         chk("rst_done_status", got_q[0].data, 64'h0);
         chk("rst_done_cycles", got_q[1].data, 64'd4);
      end

      // Reset one clock after a read drops it
      got_q.delete();
      rd(16'h002, 2'd1, 9'h055);
      reset_n = 1'b0;
      tick();
      chk("drop_tx_zero", 64'(|tx_c2), 64'd0);
      reset_n = 1'b1;
      repeat (3) tick();
      chk("drop_count", 64'(got_q.size()), 64'd0);

      // Read counter: five reads, then RD_COUNT
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) rd(16'(k * 2), 2'd1, 9'(k));
      repeat (2) tick();
      got_q.delete();
      rd(16'h064, 2'd1, 9'h007);
      tick();
      chk("stats_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() == 1) begin
`ifdef HC_MMIO_RD_STATS_EN
         chk("stats_rd_count", got_q[0].data, 64'd6);
`else
         chk("stats_rd_count", got_q[0].data, 64'd0);
`endif
      end

      // Randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         t_ccip_c0_ReqMmioHdr h;
         reset_n = ($urandom_range(99) >= 2);
         rx_c0 = '0;
         h = '0;
         case ($urandom_range(9))
            0:       h.address = 16'($urandom_range(7));
            1:       h.address = 16'(16'h044 + $urandom_range(3));
            2:       h.address = 16'(16'h048 + $urandom_range(11));
            3, 4, 5: h.address = 16'(16'h060 + $urandom_range(5));
            default: h.address = 16'($urandom);
         endcase
         h.length = 2'($urandom_range(1));
         h.tid    = 9'($urandom);
         rx_c0.hdr = h;
         if ($urandom_range(99) < 60) rx_c0.mmioRdValid = 1'b1;
         else if ($urandom_range(99) < 30) rx_c0.mmioWrValid = 1'b1;
         if ($urandom_range(99) < 10) begin
            case ($urandom_range(4))
               0:       hc_control = HC_CONTROL_ASSERT_RST;
               1:       hc_control = HC_CONTROL_DEASSERT_RST;
               2:       hc_control = HC_CONTROL_START;
               3:       hc_control = HC_CONTROL_STOP;
               default: hc_control = $urandom;
            endcase
         end
         done = ($urandom_range(99) < 4);
         if ($urandom_range(99) < 5) dsm_base = {$urandom, $urandom};
         if ($urandom_range(99) < 5)
            hc_buffer[$urandom_range(NB - 1)] = '{address: {$urandom, $urandom}, size: $urandom};
         tick();
      end
      reset_n = 1'b1;
      rx_c0 = '0;
      done = 1'b0;
      repeat (4) tick();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
